// File: rtl/mux_pipe_reg.sv
// ---------------------------------------------------------------------------
// mux_pipe_reg
//
// Registered N:1 data multiplexer with a valid/ready handshake and a 2-entry
// skid buffer.  One of CHANNELS input lanes is selected by sel_in. The chosen
// lane and the select value are captured on an input handshake, then
// presented downstream through a back-pressurable registered output.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high.  A sender holds its payload stable
// while valid is high and ready is low.  valid never waits on ready.
// ready_out and valid_out are decoded from the state register only.  They
// never depend on same-cycle inputs.
//
// Parameters:
//   WIDTH     data bits per lane (>= 1)
//   CHANNELS  number of input lanes (>= 2)
//   SEL_W     derived select width, $clog2(CHANNELS); not overridable
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous active-high reset
//   data_in     lane k occupies bits [k*WIDTH +: WIDTH]
//   sel_in      lane select, sampled on input handshake
//   valid_in    upstream offers a word
//   ready_out   block can accept a word
//   data_out    selected data (registered)
//   sel_out     lane index that produced data_out
//   valid_out   data_out/sel_out valid
//   ready_in    downstream accepts
//   count_out   completed output handshakes, wraps at 16 bits
//   err_out     sticky flag: an out-of-range select was accepted
//   parity_out  even parity of data_out (only with MUX_PIPE_REG_PARITY_EN)
//
// Optional feature macro: MUX_PIPE_REG_PARITY_EN adds parity_out and its
// storage in both the main and skid entries.
// ---------------------------------------------------------------------------
module mux_pipe_reg #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [15:0]               count_out,
    output logic                      err_out
`ifdef MUX_PIPE_REG_PARITY_EN
    ,
    output logic                      parity_out
`endif
);

    // Occupancy of the two storage entries.  The main entry drives the
    // outputs.  The skid entry is only used when a word arrives while the
    // main entry is stalled.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } fsm_state_e;

    fsm_state_e state_q;
    fsm_state_e state_d;

    logic             in_hs;
    logic             out_hs;

    logic [WIDTH-1:0] cap_data;
    logic             cap_in_range;

    logic             load_main_cap;
    logic             load_main_skid;
    logic             load_skid;

    logic [WIDTH-1:0] main_data_q;
    logic [SEL_W-1:0] main_sel_q;
    logic [WIDTH-1:0] skid_data_q;
    logic [SEL_W-1:0] skid_sel_q;

    logic [15:0]      count_q;
    logic             err_q;

    // -----------------------------------------------------------------------
    // Handshake decode (state-register driven only)
    // -----------------------------------------------------------------------
    assign valid_out = (state_q != ST_EMPTY);
    assign ready_out = (state_q != ST_TWO);

    assign in_hs  = valid_in  && (state_q != ST_TWO);
    assign out_hs = ready_in  && (state_q != ST_EMPTY);

    // -----------------------------------------------------------------------
    // Lane select.  An unmatched select (only possible when CHANNELS is not a
    // power of two) yields all-zero data and flags the error.
    // -----------------------------------------------------------------------
    always_comb begin
        cap_data     = '0;
        cap_in_range = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_in == SEL_W'(k)) begin
                cap_data     = data_in[k*WIDTH +: WIDTH];
                cap_in_range = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and storage load enables
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        load_main_cap  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    state_d       = ST_ONE;
                    load_main_cap = 1'b1;
                end
            end

            ST_ONE: begin
                if (in_hs && !out_hs) begin
                    // Main is stalled: park the new word in the skid entry.
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (!in_hs && out_hs) begin
                    state_d = ST_EMPTY;
                end else if (in_hs && out_hs) begin
                    // Main drains and refills on the same edge.
                    state_d       = ST_ONE;
                    load_main_cap = 1'b1;
                end
            end

            ST_TWO: begin
                // ready_out is low here, so only the output side can move.
                if (out_hs) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end

            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Main and skid storage.  Main is only overwritten when it is empty or
    // being consumed, so the outputs hold while stalled.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            if (load_main_cap) begin
                main_data_q <= cap_data;
                main_sel_q  <= sel_in;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_sel_q  <= skid_sel_q;
            end

            if (load_skid) begin
                skid_data_q <= cap_data;
                skid_sel_q  <= sel_in;
            end
        end
    end

    assign data_out = main_data_q;
    assign sel_out  = main_sel_q;

`ifdef MUX_PIPE_REG_PARITY_EN
    // Parity travels with its word through both entries, so it never has to
    // be recomputed on the output side.
    logic main_par_q;
    logic skid_par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_par_q <= 1'b0;
            skid_par_q <= 1'b0;
        end else begin
            if (load_main_cap) begin
                main_par_q <= ^cap_data;
            end else if (load_main_skid) begin
                main_par_q <= skid_par_q;
            end

            if (load_skid) begin
                skid_par_q <= ^cap_data;
            end
        end
    end

    assign parity_out = main_par_q;
`endif

    // -----------------------------------------------------------------------
    // Output handshake counter (free-running wrap) and sticky select error
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            if (out_hs) begin
                count_q <= count_q + 16'd1;
            end
            if (in_hs && !cap_in_range) begin
                err_q <= 1'b1;
            end
        end
    end

    assign count_out = count_q;
    assign err_out   = err_q;

endmodule

// File: doc/mux_pipe_reg.md
# mux_pipe_reg

Parametrised registered N:1 data multiplexer with a valid/ready handshake and a 2-entry skid buffer. It generalises the single-bit D flip-flop and 2:1 mux pairing into one pipelined path: CHANNELS input lanes of WIDTH bits each, a select, and a back-pressurable registered output. It sits between channel sources and a single downstream consumer.

## Interface
Parameters:
- WIDTH, 8: data bits per channel (≥1).
- CHANNELS, 4: number of input lanes (≥2).
- SEL_W, derived local parameter: $clog2(CHANNELS). Not overridable.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- data_in  input  CHANNELS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- sel_in  input  SEL_W  lane select, sampled on input handshake.
- valid_in  input  1  upstream offers a transfer.
- ready_out  output  1  block can accept; registered.
- data_out  output  WIDTH  selected data, registered.
- sel_out  output  SEL_W  lane index that produced data_out.
- valid_out  output  1  data_out/sel_out valid.
- ready_in  input  1  downstream accepts.
- count_out  output  16  output handshakes completed, wraps.
- err_out  output  1  sticky: an out-of-range select was accepted.
- parity_out  output  1  present only with MUX_PIPE_REG_PARITY_EN.

## Operation
- Input handshake: valid_in && ready_out at rising edge. Output handshake: valid_out && ready_in.
- Captured word is data_in lane sel_in plus sel_in. If sel_in ≥ CHANNELS (non-power-of-two CHANNELS only), data is all zero, sel_in is stored as given, and err_out sets to 1 on the same edge. err_out clears only on rst.
- Storage: main register (drives outputs) and skid register. State machine:
  - EMPTY: valid_out=0, ready_out=1. Input handshake → ONE (word into main).
  - ONE: valid_out=1, ready_out=1. Input only → TWO (word into skid). Output only → EMPTY. Both → ONE (new word into main).
  - TWO: valid_out=1, ready_out=0. Output handshake → ONE (skid moves to main). No input can occur.
- Ordering is strictly FIFO; no word is dropped or duplicated.
- count_out increments by 1 on each output handshake; 16'hFFFF wraps to 0.
- data_out/sel_out hold stable while valid_out=1 and ready_in=0.

## Timing
- Reset (asynchronous assertion, synchronous-edge release): state EMPTY, valid_out=0, ready_out=1, data_out=0, sel_out=0, count_out=0, err_out=0, parity_out=0. rst mid-transfer discards main and skid contents immediately.
- Latency: input handshake at edge N → valid_out=1 after edge N (visible cycle N+1) when EMPTY.
- Throughput: 1 word/cycle while ready_in stays high.
- ready_out depends on no same-cycle input (registered); valid_out does not depend combinationally on ready_in.
- ready_in may drop with valid_out high at any time; at most 2 words are held, then ready_out=0 in the cycle after the second capture.
- valid_in may assert without ready_out; upstream must hold data/sel until the handshake.

## Configuration
- MUX_PIPE_REG_PARITY_EN defined: parity_out port exists and equals XOR of data_out bits (even parity), registered alongside data_out in both main and skid, reset 0.
- Not defined: parity_out port and its storage absent; all other behaviour identical.

## Test plan
- Reset: assert rst mid-cycle, no clock → valid_out=0, ready_out=1, count_out=0, err_out=0 immediately.
- Streaming: WIDTH=8, CHANNELS=4, lanes 0xA0..0xA3, sel 0,1,2,3 back-to-back, ready_in=1 → data_out 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, sel_out 0..3, count_out=4.
- Back-pressure: ready_in=0, offer 3 words → 2 accepted, ready_out=0 after the second; release ready_in → both words emitted in order, then third accepted.
- Out-of-range: CHANNELS=3, sel_in=3 accepted → data_out=0, sel_out=3, err_out=1 and stays 1 through later valid transfers.
- Wrap: 65536 output handshakes → count_out returns to 0.
- Parity (macro defined): data_out=0x07 → parity_out=1; data_out=0x03 → parity_out=0.
